// File: rtl/program_loader_pkg.sv
// Shared types for the boot-time program loader.
// FSM states, error codes and the byte-lane count.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_LEN  = 2'b01,
    ERR_CSUM = 2'b10
  } err_t;

  localparam int LANES = 4;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master is the loader side, slave is the receiver/memory side.
interface program_loader_if #(
  parameter int DATA_WIDTH = 32
);

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Little-endian byte-to-word packer with running XOR checksum.
// word/word_ready are valid combinationally on the accepting 4th byte.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_ready,
  output logic [7:0]  csum
);

  localparam int LW = $clog2(LANES);

  logic [LW-1:0] lane;
  logic [23:0]   sh;

  // After three shifts sh holds {b2,b1,b0}; b3 arrives live.
  assign word       = {din, sh};
  assign word_ready = en && (lane == LW'(LANES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane <= '0;
      sh   <= '0;
      csum <= '0;
    end else if (en) begin
      lane <= lane + 1'b1;
      sh   <= {din, sh[23:8]};
      csum <= csum ^ din;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams bytes into instruction memory,
// holds the CPU in reset and verifies an XOR checksum.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  program_loader_if.master bus,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic [1:0]       error,
  output logic [15:0]      words_loaded
);

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] idx;
  logic [15:0] n;
  logic        take;
  logic        restart;
  logic [31:0] word;
  logic        word_ready;
  logic [7:0]  csum;

  assign take    = bus.rx_valid && bus.rx_ready;
  assign restart = start &&
                   (state == IDLE || state == DONE || state == ERROR);
  assign n       = {bus.rx_data, len_lo};

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .en         (take && state == DATA),
    .din        (bus.rx_data),
    .word       (word),
    .word_ready (word_ready),
    .csum       (csum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.rx_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= BASE_ADDRESS;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= ERR_NONE;
      words_loaded  <= '0;
      len_lo        <= '0;
      len           <= '0;
      idx           <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (bus.mem_we) begin
        idx          <= idx + 16'd1;
        words_loaded <= words_loaded + 16'd1;
      end
      unique case (state)
        IDLE, DONE, ERROR: begin
          if (restart) begin
            state        <= LEN_LO;
            bus.rx_ready <= 1'b1;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= ERR_NONE;
            words_loaded <= '0;
            idx          <= '0;
          end
        end
        LEN_LO: begin
          if (take) begin
            len_lo <= bus.rx_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (take) begin
            len <= n;
            if (n == 16'd0 || n > 16'(MEMORY_DEPTH)) begin
              state        <= ERROR;
              error        <= ERR_LEN;
              bus.rx_ready <= 1'b0;
              busy         <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (word_ready) begin
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= DATA_WIDTH'(word);
            bus.mem_addr  <= BASE_ADDRESS +
                             (DATA_WIDTH'(idx) << 2);
            // Leave DATA now so the checksum byte is never
            // consumed as data during the write cycle.
            if (idx == len - 16'd1) state <= CHECK;
          end
        end
        CHECK: begin
          if (take) begin
            bus.rx_ready <= 1'b0;
            busy         <= 1'b0;
            if (bus.rx_data == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERROR;
              error <= ERR_CSUM;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed + random load sessions against a word-level model.
// dut0 uses BASE 0, dut1 uses BASE 0x0040_0000.
module tb_program_loader;

  localparam int DEPTH = 32;
  localparam logic [31:0] BASE1 = 32'h0040_0000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  program_loader_if #(.DATA_WIDTH(32)) if0 ();
  program_loader_if #(.DATA_WIDTH(32)) if1 ();

  logic        hold0, busy0, done0, hold1, busy1, done1;
  logic [1:0]  err0, err1;
  logic [15:0] wl0, wl1;

  assign if0.rx_data  = rx_data;
  assign if1.rx_data  = rx_data;
  assign if0.rx_valid = rx_valid & ~sel;
  assign if1.rx_valid = rx_valid & sel;

  program_loader #(
    .MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32), .BASE_ADDRESS(32'h0)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start & ~sel), .bus(if0),
    .cpu_hold(hold0), .busy(busy0), .done(done0),
    .error(err0), .words_loaded(wl0)
  );

  program_loader #(
    .MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32), .BASE_ADDRESS(BASE1)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start & sel), .bus(if1),
    .cpu_hold(hold1), .busy(busy1), .done(done1),
    .error(err1), .words_loaded(wl1)
  );

  logic        o_ready, o_we, o_hold, o_busy, o_done;
  logic [31:0] o_addr, o_wdata;
  logic [1:0]  o_err;
  logic [15:0] o_wl;

  assign o_ready = sel ? if1.rx_ready  : if0.rx_ready;
  assign o_we    = sel ? if1.mem_we    : if0.mem_we;
  assign o_addr  = sel ? if1.mem_addr  : if0.mem_addr;
  assign o_wdata = sel ? if1.mem_wdata : if0.mem_wdata;
  assign o_hold  = sel ? hold1 : hold0;
  assign o_busy  = sel ? busy1 : busy0;
  assign o_done  = sel ? done1 : done0;
  assign o_err   = sel ? err1  : err0;
  assign o_wl    = sel ? wl1   : wl0;

  always #5 clk = ~clk;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [31:0] words[DEPTH];
  bit          ready_drop;

  always @(negedge clk) begin
    if (o_we) begin
      wq_addr.push_back(o_addr);
      wq_data.push_back(o_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!o_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w != 0) chk("rx_ready_wait", w, 0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int stall);
    repeat (stall) begin
      @(negedge clk);
      if (!o_ready) ready_drop = 1'b1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_outcome(input int n, input bit bad,
                               input logic [31:0] base);
    bit ok;
    int nw;
    ok = (n != 0) && (n <= DEPTH);
    nw = ok ? n : 0;
    chk("write_count", wq_addr.size(), nw);
    for (int i = 0; i < nw && i < wq_addr.size(); i++) begin
      chk($sformatf("addr[%0d]", i), wq_addr[i], base + 32'(4 * i));
      chk($sformatf("data[%0d]", i), wq_data[i], words[i]);
    end
    chk("error", o_err, !ok ? 2'b01 : (bad ? 2'b10 : 2'b00));
    chk("done", o_done, ok && !bad);
    chk("cpu_hold", o_hold, !(ok && !bad));
    chk("busy", o_busy, 0);
    chk("rx_ready", o_ready, 0);
    chk("words_loaded", o_wl, nw);
    chk("ready_held", ready_drop, 0);
  endtask

  task automatic session(input int n, input bit bad, input int stall,
                         input bit poke, input logic [31:0] base);
    logic [7:0] cs, b;
    logic [15:0] len;
    len = 16'(n);
    cs = 8'h00;
    wq_addr.delete();
    wq_data.delete();
    ready_drop = 1'b0;
    pulse_start();
    send_byte(len[7:0]);
    gap(stall);
    send_byte(len[15:8]);
    if (n != 0 && n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) begin
          b = 8'((words[i] >> (8 * k)) & 32'hFF);
          cs = cs ^ b;
          gap(stall);
          send_byte(b);
          if (poke && k == 1 && (i % 8) == 3) pulse_start();
        end
      end
      gap(stall);
      send_byte(cs ^ {7'b0, bad});
    end
    repeat (3) @(negedge clk);
    check_outcome(n, bad, base);
  endtask

  task automatic check_reset(input logic [31:0] base);
    chk("rst_rx_ready", o_ready, 0);
    chk("rst_mem_we", o_we, 0);
    chk("rst_mem_addr", o_addr, base);
    chk("rst_mem_wdata", o_wdata, 0);
    chk("rst_cpu_hold", o_hold, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_err, 0);
    chk("rst_words_loaded", o_wl, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset(32'h0);
    sel = 1'b1;
    #1 check_reset(BASE1);
    sel = 1'b0;
    @(negedge clk);

    // nominal
    words[0] = 32'h2008_000A;
    words[1] = 32'h0000_0000;
    session(2, 1'b0, 0, 1'b0, 32'h0);
    // stalled stream
    session(2, 1'b0, 3, 1'b0, 32'h0);
    // bad lengths
    session(0, 1'b0, 0, 1'b0, 32'h0);
    session(33, 1'b0, 0, 1'b0, 32'h0);
    // checksum mismatch then recovery
    session(2, 1'b1, 0, 1'b0, 32'h0);
    session(2, 1'b0, 0, 1'b0, 32'h0);

    // reset after 5 data bytes
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    for (int k = 0; k < 5; k++) send_byte(8'h11 * 8'(k + 1));
    reset = 1'b1;
    @(negedge clk);
    check_reset(32'h0);
    reset = 1'b0;
    @(negedge clk);
    words[0] = 32'hDEAD_BEEF;
    words[1] = 32'h1234_5678;
    session(2, 1'b0, 1, 1'b0, 32'h0);

    // full depth on the offset-base instance, start pokes in DATA
    sel = 1'b1;
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    session(DEPTH, 1'b0, 0, 1'b1, BASE1);
    if (wq_addr.size() == DEPTH)
      chk("last_addr", wq_addr[DEPTH-1], 32'h0040_007C);
    sel = 1'b0;
    @(negedge clk);

    // random sessions
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
      n = $urandom_range(0, 36);
      session(n, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
              1'($urandom_range(0, 1)), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
